tty_char_writer: RTL and testbench
==================================

// Module: tty_char_writer
// PURPOSE
//  Byte-stream terminal front end for the character buffer. Accepts ASCII bytes over a
//  valid/ready handshake and issues one cell write per cycle on the buffer's write port
//  (hpos, vpos, write_en, symbol). Tracks and publishes the cursor, interprets CR/LF/BS/FF,
//  and wraps at line and screen end by blanking the new line. Sits between a UART RX or CPU
//  and the buffer.
// PARAMETERS
//  CHAR_HORZ_CNT  16                       columns; must match the buffer
//  CHAR_VERT_CNT  2                        rows; must match the buffer
//  CHAR_HORZ_W    $clog2(CHAR_HORZ_CNT)    column index width
//  CHAR_VERT_W    $clog2(CHAR_VERT_CNT)    row index width
//  TAB_WIDTH      4                        tab stop spacing; power of 2, <= CHAR_HORZ_CNT
//  BLANK_CHAR     8'h20                    symbol written when clearing
// PORTS
//  clk            in   1            single clock
//  rst_n          in   1            asynchronous, active-low reset
//  in_valid       in   1            in_data is valid
//  in_ready       out  1            block can accept a byte this cycle
//  in_data        in   8            ASCII byte
//  char_hpos      out  CHAR_HORZ_W  write column
//  char_vpos      out  CHAR_VERT_W  write row
//  char_write_en  out  1            one-cycle write strobe
//  char_symbol    out  8            symbol to write
//  cursor_valid   out  1            cursor outputs are meaningful
//  cursor_hpos    out  CHAR_HORZ_W  current cursor column
//  cursor_vpos    out  CHAR_VERT_W  current cursor row
// BEHAVIOUR
//  - Reset (rst_n low): all outputs 0, cursor (0,0), state CLR_SCREEN armed. Reset asserted
//    mid-operation aborts it; there is no pending-byte memory.
//  - Handshake: a byte transfers when in_valid & in_ready. The source holds in_data until it
//    transfers. in_ready = (state==IDLE), registered.
//  - Timing: all write-port outputs are registered; a strobe appears 1 cycle after the
//    accept/step that caused it. The cursor updates in the same edge.
//  - States: IDLE, CLR_LINE, CLR_SCREEN, TAB (TAB only with macro).
//  - CLR_SCREEN: entered after reset and on FF (0x0C). Writes BLANK_CHAR to every cell,
//    row-major: (0,0),(1,0)..(N-1,M-1), one per cycle. Then cursor=(0,0), goes to IDLE.
//    Length = CHAR_HORZ_CNT*CHAR_VERT_CNT cycles.
//  - Printable 0x20..0x7E: write at cursor, then column+1.
//    - Last column: column=0, row+1; row wraps from CHAR_VERT_CNT-1 to 0.
//    - Any row change caused by wrap enters CLR_LINE.
//  - LF 0x0A: column=0, row+1 (same wrap rule), enter CLR_LINE. No write.
//  - CR 0x0D: column=0, no write. BS 0x08: column-1 if >0, else no-op; no erase.
//  - Other bytes (0x00..0x1F not listed, 0x7F..0xFF): accepted and dropped; 1 cycle.
//  - CLR_LINE: writes BLANK_CHAR to columns 0..CHAR_HORZ_CNT-1 of the cursor row, one per
//    cycle, then IDLE. Cursor stays at (0,row) throughout.
//  - cursor_valid = 1 only in IDLE, and only when reset is not in progress. It is 0 during
//    CLR_LINE, CLR_SCREEN and TAB.
//  - Counters are sized exactly to CHAR_*_W. Non-power-of-2 counts use explicit compare at
//    CNT-1; there is no modulo by overflow.
// CONFIGURATION
//  TTY_CHAR_WRITER_TAB_EN defined:
//  - TAB 0x09 enters TAB state and writes BLANK_CHAR at the cursor, advancing one per cycle,
//    until column % TAB_WIDTH == 0. At least one blank is always written.
//  - Reaching end of line during TAB follows the printable wrap rule, then returns to IDLE.
//  TTY_CHAR_WRITER_TAB_EN undefined: 0x09 is dropped like other control codes; no TAB state.
// TESTING
//  1. Release rst_n -> 32 strobes of 0x20 covering (0,0)..(15,1) row-major; in_ready rises
//     on the next cycle; cursor_valid=1 at (0,0).
//  2. Send 'A' (0x41) -> next cycle strobe (0,0,0x41); cursor (1,0).
//  3. Send 16 x 'B' from (0,0) -> 16 writes to row 0; cursor (0,1); in_ready low for 16
//     cycles while blanking row 1. Then 16 more -> cursor (0,0), row 0 blanked.
//  4. At (0,0) send BS -> no write, cursor (0,0). Send "xy",CR,'z' -> 'z' written at (0,0).
//  5. TAB at (1,0): with macro -> blanks at cols 1,2,3, cursor (4,0). Without macro ->
//     no write, cursor (1,0).
//  6. Send FF, then drop rst_n at the 5th blank -> outputs zeroed. On release, full
//     32-cell clear restarts from (0,0).

Source files
------------

// File: rtl/tty_char_writer_if.sv
// Byte-stream and character-buffer write-port bundle for tty_char_writer.
// master: byte source side (drives in_valid/in_data, observes everything else).
// slave : the writer itself.
interface tty_char_writer_if #(
  parameter int CHAR_HORZ_W = 4,
  parameter int CHAR_VERT_W = 1
);
  logic                   in_valid;
  logic                   in_ready;
  logic [7:0]             in_data;
  logic [CHAR_HORZ_W-1:0] char_hpos;
  logic [CHAR_VERT_W-1:0] char_vpos;
  logic                   char_write_en;
  logic [7:0]             char_symbol;
  logic                   cursor_valid;
  logic [CHAR_HORZ_W-1:0] cursor_hpos;
  logic [CHAR_VERT_W-1:0] cursor_vpos;

  modport master (
    output in_valid, in_data,
    input  in_ready, char_hpos, char_vpos, char_write_en, char_symbol,
           cursor_valid, cursor_hpos, cursor_vpos
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, char_hpos, char_vpos, char_write_en, char_symbol,
           cursor_valid, cursor_hpos, cursor_vpos
  );
endinterface

// File: rtl/tty_char_writer.sv
// Terminal front end for the character buffer: accepts ASCII bytes, issues one
// cell write per cycle, tracks the cursor, handles CR/LF/BS/FF and line/screen
// wrap (new line is blanked). Optional tab expansion is enabled by defining
// TTY_CHAR_WRITER_TAB_EN.
module tty_char_writer #(
  parameter int         CHAR_HORZ_CNT = 16,
  parameter int         CHAR_VERT_CNT = 2,
  parameter int         CHAR_HORZ_W   = $clog2(CHAR_HORZ_CNT),
  parameter int         CHAR_VERT_W   = $clog2(CHAR_VERT_CNT),
  parameter int         TAB_WIDTH     = 4,
  parameter logic [7:0] BLANK_CHAR    = 8'h20
) (
  input  logic               clk,
  input  logic               rst_n,
  tty_char_writer_if.slave   bus
);

  localparam logic [CHAR_HORZ_W-1:0] H_LAST   = CHAR_HORZ_W'(CHAR_HORZ_CNT - 1);
  localparam logic [CHAR_VERT_W-1:0] V_LAST   = CHAR_VERT_W'(CHAR_VERT_CNT - 1);
  localparam logic [CHAR_HORZ_W-1:0] TAB_MASK = CHAR_HORZ_W'(TAB_WIDTH - 1);

`ifdef TTY_CHAR_WRITER_TAB_EN
  typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_SCREEN, TAB} state_t;
`else
  typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_SCREEN} state_t;
`endif

  state_t                 state, state_nxt;
  logic [CHAR_HORZ_W-1:0] cur_h, cur_h_nxt;
  logic [CHAR_VERT_W-1:0] cur_v, cur_v_nxt;
  logic [CHAR_HORZ_W-1:0] cnt_h, cnt_h_nxt;
  logic [CHAR_VERT_W-1:0] cnt_v, cnt_v_nxt;
  logic [CHAR_HORZ_W-1:0] wr_h, wr_h_nxt;
  logic [CHAR_VERT_W-1:0] wr_v, wr_v_nxt;
  logic [7:0]             wr_sym, wr_sym_nxt;
  logic                   wr_en, wr_en_nxt;
  logic                   idle_q;

  // Column/row advance with explicit compare at the last index (no overflow wrap).
  function automatic logic [CHAR_HORZ_W-1:0] col_inc(input logic [CHAR_HORZ_W-1:0] c);
    return (c == H_LAST) ? '0 : c + 1'b1;
  endfunction

  function automatic logic [CHAR_VERT_W-1:0] row_inc(input logic [CHAR_VERT_W-1:0] r);
    return (r == V_LAST) ? '0 : r + 1'b1;
  endfunction

  function automatic logic is_tab_stop(input logic [CHAR_HORZ_W-1:0] c);
    return (c & TAB_MASK) == '0;
  endfunction

  function automatic logic is_printable(input logic [7:0] d);
    return (d >= 8'h20) && (d <= 8'h7E);
  endfunction

  // State, cursor, scan counters and registered write-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= CLR_SCREEN;
      cur_h  <= '0;
      cur_v  <= '0;
      cnt_h  <= '0;
      cnt_v  <= '0;
      wr_h   <= '0;
      wr_v   <= '0;
      wr_sym <= '0;
      wr_en  <= 1'b0;
      idle_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cur_h  <= cur_h_nxt;
      cur_v  <= cur_v_nxt;
      cnt_h  <= cnt_h_nxt;
      cnt_v  <= cnt_v_nxt;
      wr_h   <= wr_h_nxt;
      wr_v   <= wr_v_nxt;
      wr_sym <= wr_sym_nxt;
      wr_en  <= wr_en_nxt;
      idle_q <= (state_nxt == IDLE);
    end
  end

  // Next-state, cursor movement and the cell write for this step.
  always_comb begin
    state_nxt  = state;
    cur_h_nxt  = cur_h;
    cur_v_nxt  = cur_v;
    cnt_h_nxt  = cnt_h;
    cnt_v_nxt  = cnt_v;
    wr_h_nxt   = wr_h;
    wr_v_nxt   = wr_v;
    wr_sym_nxt = wr_sym;
    wr_en_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (is_printable(bus.in_data)) begin
            wr_en_nxt  = 1'b1;
            wr_h_nxt   = cur_h;
            wr_v_nxt   = cur_v;
            wr_sym_nxt = bus.in_data;
            cur_h_nxt  = col_inc(cur_h);
            if (cur_h == H_LAST) begin
              cur_v_nxt = row_inc(cur_v);
              cnt_h_nxt = '0;
              state_nxt = CLR_LINE;
            end
          end else begin
            case (bus.in_data)
              8'h0A: begin
                cur_h_nxt = '0;
                cur_v_nxt = row_inc(cur_v);
                cnt_h_nxt = '0;
                state_nxt = CLR_LINE;
              end
              8'h0D: cur_h_nxt = '0;
              8'h08: if (cur_h != '0) cur_h_nxt = cur_h - 1'b1;
              8'h0C: begin
                cur_h_nxt = '0;
                cur_v_nxt = '0;
                cnt_h_nxt = '0;
                cnt_v_nxt = '0;
                state_nxt = CLR_SCREEN;
              end
`ifdef TTY_CHAR_WRITER_TAB_EN
              8'h09: state_nxt = TAB;
`endif
              default: ;
            endcase
          end
        end
      end
      CLR_LINE: begin
        wr_en_nxt  = 1'b1;
        wr_h_nxt   = cnt_h;
        wr_v_nxt   = cur_v;
        wr_sym_nxt = BLANK_CHAR;
        cnt_h_nxt  = col_inc(cnt_h);
        if (cnt_h == H_LAST) state_nxt = IDLE;
      end
      CLR_SCREEN: begin
        wr_en_nxt  = 1'b1;
        wr_h_nxt   = cnt_h;
        wr_v_nxt   = cnt_v;
        wr_sym_nxt = BLANK_CHAR;
        cnt_h_nxt  = col_inc(cnt_h);
        if (cnt_h == H_LAST) begin
          cnt_v_nxt = row_inc(cnt_v);
          if (cnt_v == V_LAST) begin
            cur_h_nxt = '0;
            cur_v_nxt = '0;
            state_nxt = IDLE;
          end
        end
      end
`ifdef TTY_CHAR_WRITER_TAB_EN
      TAB: begin
        wr_en_nxt  = 1'b1;
        wr_h_nxt   = cur_h;
        wr_v_nxt   = cur_v;
        wr_sym_nxt = BLANK_CHAR;
        cur_h_nxt  = col_inc(cur_h);
        if (cur_h == H_LAST) begin
          cur_v_nxt = row_inc(cur_v);
          cnt_h_nxt = '0;
          state_nxt = CLR_LINE;
        end else if (is_tab_stop(col_inc(cur_h))) begin
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready      = idle_q;
  assign bus.cursor_valid  = idle_q;
  assign bus.cursor_hpos   = cur_h;
  assign bus.cursor_vpos   = cur_v;
  assign bus.char_hpos     = wr_h;
  assign bus.char_vpos     = wr_v;
  assign bus.char_write_en = wr_en;
  assign bus.char_symbol   = wr_sym;

endmodule

// File: tb/tb_tty_char_writer.sv
// Bench for tty_char_writer: directed vector table, hand-written reset and
// wrap sequences, and random bytes checked against a screen/cursor model.
module tb_tty_char_writer;
  localparam int H  = 16;
  localparam int V  = 2;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tty_char_writer_if #(.CHAR_HORZ_W(4), .CHAR_VERT_W(1)) bus ();

  tty_char_writer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {int h; int v; int s;} wr_t;
  typedef struct {int d; int h; int v; int nw; int busy; int w0h; int w0v; int w0s;} vec_t;

  wr_t obs[$];
  wr_t expq[$];
  int  scr  [V][H];
  int  dscr [V][H];
  int  mh, mv;
  int  n_cmp = 0;
  int  n_fail = 0;

  // Record every strobe seen on the write port.
  always @(negedge clk) begin
    if (bus.char_write_en) begin
      wr_t w;
      w.h = int'(bus.char_hpos);
      w.v = int'(bus.char_vpos);
      w.s = int'(bus.char_symbol);
      obs.push_back(w);
      dscr[w.v][w.h] = w.s;
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic mpush(input int h, input int v, input int s);
    wr_t w;
    w.h = h; w.v = v; w.s = s;
    expq.push_back(w);
    scr[v][h] = s;
  endtask

  task automatic m_newline();
    mh = 0;
    mv = (mv + 1) % V;
    for (int h = 0; h < H; h++) mpush(h, mv, 8'h20);
  endtask

  task automatic model_clear();
    for (int v = 0; v < V; v++)
      for (int h = 0; h < H; h++) mpush(h, v, 8'h20);
    mh = 0;
    mv = 0;
  endtask

  task automatic model_byte(input int b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      mpush(mh, mv, b);
      mh++;
      if (mh == H) m_newline();
    end else if (b == 8'h0A) begin
      m_newline();
    end else if (b == 8'h0D) begin
      mh = 0;
    end else if (b == 8'h08) begin
      if (mh > 0) mh--;
    end else if (b == 8'h0C) begin
      model_clear();
`ifdef TTY_CHAR_WRITER_TAB_EN
    end else if (b == 8'h09) begin
      do begin
        mpush(mh, mv, 8'h20);
        mh++;
        if (mh == H) begin
          m_newline();
          break;
        end
      end while (mh % TW != 0);
`endif
    end
  endtask

  // ---------------- driver / comparisons ----------------
  task automatic send_byte(input int b, output int busy);
    int t;
    busy = 0;
    t = 0;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    if (!bus.in_ready) chk("ready_before_send", 0, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = b[7:0];
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    t = 0;
    do begin
      @(negedge clk); #1;
      if (!bus.in_ready) busy++;
      t++;
    end while (!bus.in_ready && t < 200);
    if (!bus.in_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic cmp_writes(input string nm);
    int bad;
    int n;
    chk({nm, "_nwrites"}, obs.size(), expq.size());
    bad = -1;
    n = (obs.size() < expq.size()) ? obs.size() : expq.size();
    for (int i = 0; i < n; i++)
      if (bad < 0 && (obs[i].h != expq[i].h || obs[i].v != expq[i].v || obs[i].s != expq[i].s))
        bad = i;
    n_cmp++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s_seq[%0d]: got (%0d,%0d,%02h), expected (%0d,%0d,%02h)", nm, bad,
               obs[bad].h, obs[bad].v, obs[bad].s, expq[bad].h, expq[bad].v, expq[bad].s);
    end
  endtask

  task automatic do_byte(input string nm, input int b, output int busy, output int nw);
    obs.delete();
    expq.delete();
    model_byte(b);
    send_byte(b, busy);
    nw = obs.size();
    cmp_writes(nm);
    chk({nm, "_cur_h"}, int'(bus.cursor_hpos), mh);
    chk({nm, "_cur_v"}, int'(bus.cursor_vpos), mv);
    chk({nm, "_cur_valid"}, int'(bus.cursor_valid), 1);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_in_ready"}, int'(bus.in_ready), 0);
    chk({nm, "_cursor_valid"}, int'(bus.cursor_valid), 0);
    chk({nm, "_write_en"}, int'(bus.char_write_en), 0);
    chk({nm, "_hpos"}, int'(bus.char_hpos), 0);
    chk({nm, "_vpos"}, int'(bus.char_vpos), 0);
    chk({nm, "_symbol"}, int'(bus.char_symbol), 0);
    chk({nm, "_cursor_h"}, int'(bus.cursor_hpos), 0);
    chk({nm, "_cursor_v"}, int'(bus.cursor_vpos), 0);
  endtask

  // Called with rst_n low: release it and check the full-screen clear.
  task automatic release_and_check(input string nm);
    int busy;
    int t;
    obs.delete();
    expq.delete();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    busy = 0;
    t = 0;
    do begin
      @(negedge clk); #1;
      if (!bus.in_ready) busy++;
      t++;
    end while (!bus.in_ready && t < 200);
    cmp_writes(nm);
    chk({nm, "_busy"}, busy, 31);
    chk({nm, "_cursor_valid"}, int'(bus.cursor_valid), 1);
    chk({nm, "_cur_h"}, int'(bus.cursor_hpos), 0);
    chk({nm, "_cur_v"}, int'(bus.cursor_vpos), 0);
    @(negedge clk); #1;
    chk({nm, "_strobe_done"}, int'(bus.char_write_en), 0);
  endtask

  vec_t tbl[15];

  initial begin
    int busy, nw, bad, b, r, t;
    bit pr;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    mh = 0;
    mv = 0;

    // Reset values and the power-up clear.
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    release_and_check("powerup_clear");

    // Directed vectors from a blank screen with cursor (0,0).
    tbl[0]  = '{8'h41, 1, 0, 1, 0, 0, 0, 8'h41};
    tbl[1]  = '{8'h08, 0, 0, 0, 0, -1, -1, -1};
    tbl[2]  = '{8'h08, 0, 0, 0, 0, -1, -1, -1};
    tbl[3]  = '{8'h78, 1, 0, 1, 0, 0, 0, 8'h78};
    tbl[4]  = '{8'h79, 2, 0, 1, 0, 1, 0, 8'h79};
    tbl[5]  = '{8'h0D, 0, 0, 0, 0, -1, -1, -1};
    tbl[6]  = '{8'h7A, 1, 0, 1, 0, 0, 0, 8'h7A};
    tbl[7]  = '{8'h7F, 1, 0, 0, 0, -1, -1, -1};
    tbl[8]  = '{8'h00, 1, 0, 0, 0, -1, -1, -1};
`ifdef TTY_CHAR_WRITER_TAB_EN
    tbl[9]  = '{8'h09, 4, 0, 3, 3, 1, 0, 8'h20};
`else
    tbl[9]  = '{8'h09, 1, 0, 0, 0, -1, -1, -1};
`endif
    tbl[10] = '{8'h0A, 0, 1, 16, 16, 0, 1, 8'h20};
    tbl[11] = '{8'h7E, 1, 1, 1, 0, 0, 1, 8'h7E};
    tbl[12] = '{8'h0D, 0, 1, 0, 0, -1, -1, -1};
    tbl[13] = '{8'h0C, 0, 0, 32, 32, 0, 0, 8'h20};
    tbl[14] = '{8'hFF, 0, 0, 0, 0, -1, -1, -1};
    for (int i = 0; i < 15; i++) begin
      do_byte($sformatf("tbl%0d", i), tbl[i].d, busy, nw);
      chk($sformatf("tbl%0d_h", i), int'(bus.cursor_hpos), tbl[i].h);
      chk($sformatf("tbl%0d_v", i), int'(bus.cursor_vpos), tbl[i].v);
      chk($sformatf("tbl%0d_nw", i), nw, tbl[i].nw);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      if (tbl[i].w0s >= 0) begin
        chk($sformatf("tbl%0d_w0h", i), (obs.size() > 0) ? obs[0].h : -1, tbl[i].w0h);
        chk($sformatf("tbl%0d_w0v", i), (obs.size() > 0) ? obs[0].v : -1, tbl[i].w0v);
        chk($sformatf("tbl%0d_w0s", i), (obs.size() > 0) ? obs[0].s : -1, tbl[i].w0s);
      end
    end

    // Line wrap: 16 x 'B' fills row 0 and blanks row 1, 16 more wrap the screen.
    for (int i = 0; i < 16; i++) do_byte("wrapB1", 8'h42, busy, nw);
    chk("wrapB1_h", int'(bus.cursor_hpos), 0);
    chk("wrapB1_v", int'(bus.cursor_vpos), 1);
    chk("wrapB1_busy", busy, 16);
    for (int i = 0; i < 16; i++) do_byte("wrapB2", 8'h42, busy, nw);
    chk("wrapB2_h", int'(bus.cursor_hpos), 0);
    chk("wrapB2_v", int'(bus.cursor_vpos), 0);
    chk("wrapB2_busy", busy, 16);
    bad = 0;
    for (int h = 0; h < H; h++) begin
      if (dscr[0][h] != 8'h20) bad++;
      if (dscr[1][h] != 8'h42) bad++;
    end
    chk("wrapB_screen_bad_cells", bad, 0);

    // Random bytes against the model.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      b = $urandom_range(32, 126);
      else if (r < 68) b = 8'h0D;
      else if (r < 78) b = 8'h0A;
      else if (r < 84) b = 8'h08;
      else if (r < 90) b = 8'h09;
      else if (r < 92) b = 8'h0C;
      else             b = $urandom_range(0, 255);
      pr = (b >= 8'h20 && b <= 8'h7E);
      do_byte($sformatf("rnd%0d_%02h", n, b), b, busy, nw);
      chk($sformatf("rnd%0d_busy", n), busy, expq.size() - (pr ? 1 : 0));
    end
    bad = 0;
    for (int v = 0; v < V; v++)
      for (int h = 0; h < H; h++)
        if (dscr[v][h] != scr[v][h]) bad++;
    chk("rnd_screen_bad_cells", bad, 0);

    // FF, then reset asserted at the 5th blank: outputs drop, clear restarts.
    obs.delete();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h0C;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    t = 0;
    while (obs.size() < 5 && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    chk("ff_abort_reached5", obs.size(), 5);
    chk("ff_abort_5th_h", (obs.size() > 4) ? obs[4].h : -1, 4);
    rst_n = 1'b0;
    #1;
    check_zero("ff_abort");
    release_and_check("ff_abort_clear");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
